// File: rtl/bcd_xs3_seq_ctrl.sv
// Two-port sequencer sharing one 4-bit 8421/excess-3 digit converter.
// Words are converted one digit per cycle, LSD first, with a sticky invalid-digit flag.
module bcd_xs3_seq_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_mode,
    input  logic [4*DIGITS-1:0] req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_mode,
    input  logic [4*DIGITS-1:0] req1_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [4*DIGITS-1:0] rsp_data,
    output logic                rsp_err,
    output logic                rsp_id,
    output logic                busy
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0]  data_reg;
    logic          mode_reg;
    logic          id_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  result_reg;
    logic [W-1:0]  result_next;
    logic          err_reg;
    logic          last_grant_reg;

    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          accept_id;
    logic          conv_step;
    logic          rsp_fire;

    logic [3:0]    src_digit [DIGITS];
    logic [3:0]    cur_digit;
    logic [3:0]    conv_digit;
    logic          digit_ok;

    // Round-robin: on a tie the port that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant_reg;
            grant1 = ~last_grant_reg;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode; ready is gated by rst_n so it drops immediately in reset
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        conv_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                req0_ready = grant0 & req0_valid & rst_n;
                req1_ready = grant1 & req1_valid & rst_n;
            end
            CONV: begin
                busy      = 1'b1;
                conv_step = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign accept    = req0_ready | req1_ready;
    assign accept_id = req1_ready;
    assign rsp_fire  = rsp_valid & rsp_ready;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_src
            assign src_digit[gi] = data_reg[gi*4 +: 4];
        end
    endgenerate

    // Shared digit converter
    assign cur_digit  = src_digit[cnt_reg];
    assign conv_digit = mode_reg ? (cur_digit - 4'd3) : (cur_digit + 4'd3);
    assign digit_ok   = mode_reg ? ((cur_digit >= 4'd3) && (cur_digit <= 4'd12))
                                 : (cur_digit <= 4'd9);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_res
            assign result_next[gi*4 +: 4] =
                (conv_step && (cnt_reg == CW'(gi))) ? conv_digit : result_reg[gi*4 +: 4];
        end
    endgenerate

    // Transaction datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg       <= '0;
            mode_reg       <= 1'b0;
            id_reg         <= 1'b0;
            cnt_reg        <= '0;
            result_reg     <= '0;
            err_reg        <= 1'b0;
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            data_reg       <= accept_id ? req1_data : req0_data;
            mode_reg       <= accept_id ? req1_mode : req0_mode;
            id_reg         <= accept_id;
            last_grant_reg <= accept_id;
            cnt_reg        <= '0;
            result_reg     <= '0;
            err_reg        <= 1'b0;
        end else if (conv_step) begin
            result_reg <= result_next;
            err_reg    <= err_reg | ~digit_ok;
            cnt_reg    <= (cnt_reg == CNT_LAST) ? '0 : CW'(cnt_reg + 1'b1);
        end
    end

    assign rsp_data = result_reg;
    assign rsp_err  = err_reg;
    assign rsp_id   = id_reg;

endmodule

// File: doc/bcd_xs3_seq_ctrl.md
# bcd_xs3_seq_ctrl

Sequencing controller that shares one 4-bit 8421-BCD/excess-3 digit converter between two requesters. Each request carries a packed multi-digit word and a direction. The controller arbitrates round-robin, steps the converter through the word one digit per cycle (least-significant digit first), checks each digit for validity, and returns the converted word with an error flag over a valid/ready response channel. It sits between code-conversion clients and the shared combinational converter datapath.

## Interface
- DIGITS, 4, number of 4-bit BCD digits per word (1..8)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle (combinational)
- req0_mode  in  1  0 = 8421 to excess-3 (+3 per digit), 1 = excess-3 to 8421 (-3 per digit)
- req0_data  in  4*DIGITS  packed digits, digit 0 in [3:0]
- req1_valid, req1_ready, req1_mode, req1_data  same as port 0, for port 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  4*DIGITS  converted word
- rsp_err  out  1  at least one source digit invalid
- rsp_id  out  1  port that issued this response
- busy  out  1  high in CONV or DONE

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE: if any reqN_valid, grant one port; reqN_ready = (state==IDLE) & grant_N & reqN_valid & rst_n. Acceptance is valid & ready at a rising edge. On acceptance: latch data, mode, and id; clear the digit counter, result, and error; go to CONV.
- Arbitration: if only one port is valid, that port wins. If both are valid, the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie.
- CONV: each cycle, convert digit[cnt] with out = in + 4'd3 (mode 0) or in - 4'd3 (mode 1), modulo 16. Write the result into rsp_data digit cnt. Increment cnt. After digit DIGITS-1, go to DONE.
- Digit validity: mode 0 requires 0..9. Mode 1 requires 3..12. An invalid digit is still converted modulo 16, and it sets the sticky err bit.
- DONE: rsp_valid=1. rsp_data, rsp_err, and rsp_id are held stable until rsp_valid & rsp_ready at an edge, then go to IDLE.
- Requests are not accepted in CONV or DONE. Both reqN_ready are 0 there. The source must hold its valid and data until accepted.
- A requester's valid/data may change while it is not granted. The block latches only at acceptance.

## Timing
- Reset (async, immediate): state IDLE, cnt 0, rsp_valid 0, rsp_data 0, rsp_err 0, rsp_id 0, busy 0, req0_ready 0, req1_ready 0, last_grant 1.
- Reset mid-operation: the in-flight transaction is discarded and no response is issued. The first request after rst_n deasserts is handled normally.
- Latency: acceptance at edge E0. rsp_valid is high after edge E0+DIGITS (DIGITS cycles later).
- Earliest next acceptance is the cycle after the response handshake edge. Minimum period is DIGITS+2 cycles per transaction.
- The response channel has no bypass: rsp_ready does not affect reqN_ready combinationally.
- rsp_data accumulates partial results during CONV. Consumers sample it only while rsp_valid=1.

## Test plan
- DIGITS=4, rsp_ready=1. Port 0, mode 0, data 16'h1234 -> rsp_data 16'h4567, rsp_err 0, rsp_id 0. rsp_valid rises 4 cycles after acceptance and is high for one cycle.
- Port 1, mode 1, data 16'hC333 -> rsp_data 16'h9000, rsp_err 0, rsp_id 1.
- Invalid digits:
  - Port 0, mode 0, data 16'h00A9 -> rsp_data 16'h33DC, rsp_err 1.
  - Mode 1, data 16'h3332 -> rsp_data 16'h000F, rsp_err 1.
- Arbitration: both ports valid out of reset -> port 0 served, then port 1. Both re-asserted -> port 0 again. Responses carry rsp_id 0, 1, 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data, and rsp_id stay stable, both reqN_ready stay 0, and busy is 1. Raising rsp_ready completes the response, and the pending request is accepted the next cycle.
- Pulse rst_n low during CONV (after digit 1) -> all outputs go to 0 immediately and no response is issued. After release, a fresh request (16'h0987, mode 0) yields 16'h3CBA with err 0.
